// File: rtl/pe_sched_pkg.sv
// Shared types, sizes and helpers for the PE cluster scheduler.
package pe_sched_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned MAX_K   = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned T_W     = IDX_W + 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic CLIENT_QK = 1'b0;
  localparam logic CLIENT_AV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE
  } state_t;

  // Reduction length of 0 still runs one step; anything above MAX_K saturates.
  function automatic logic [IDX_W-1:0] clamp_k(input logic [IDX_W-1:0] k);
    if (k == '0) return IDX_W'(1);
    else if (k > IDX_W'(MAX_K)) return IDX_W'(MAX_K);
    else return k;
  endfunction

endpackage

// File: rtl/pe_cluster_sched_if.sv
// Request/operand-feed bundle between the attention controller, the scheduler and the PE cluster.
interface pe_cluster_sched_if;
  import pe_sched_pkg::*;

  logic                     en;
  logic [1:0]               req;
  logic [IDX_W-1:0]         k_len0;
  logic [IDX_W-1:0]         k_len1;
  logic [1:0]               grant;
  logic                     cluster_clr;
  logic [LANES-1:0]         lane_valid;
  logic [LANES*IDX_W-1:0]   lane_idx;
  logic [LANES-1:0]         lane_done;
  logic [LANES*LANES-1:0]   pe_done;
  logic                     capture;
  logic                     pass_done;
  logic                     err;

  modport master (
    output en, req, k_len0, k_len1, pe_done,
    input  grant, cluster_clr, lane_valid, lane_idx, lane_done, capture, pass_done, err
  );

  modport slave (
    input  en, req, k_len0, k_len1, pe_done,
    output grant, cluster_clr, lane_valid, lane_idx, lane_done, capture, pass_done, err
  );

endinterface

// File: rtl/pe_rr_arb2.sv
// Two-requester round-robin arbiter; the last-winner pointer advances only on pass capture.
module pe_rr_arb2
  import pe_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_win,
  output logic       o_win_c,
  output logic       o_any_c
);

  logic r_last;

  // Reset as if client 1 was served last, so client 0 has priority.
  always_ff @(posedge clk) begin
    if (rst)        r_last <= CLIENT_AV;
    else if (i_upd) r_last <= i_upd_win;
  end

  always_comb begin
    o_any_c = |i_req;
    if (i_req == 2'b11) o_win_c = ~r_last;
    else                o_win_c = i_req[1] ? CLIENT_AV : CLIENT_QK;
  end

endmodule

// File: rtl/pe_cluster_sched.sv
// Shares one LANES x LANES PE cluster between the QK and AV passes: arbitrate, clear, skewed feed, drain, capture.
// Optional DRAIN watchdog enabled by defining PE_SCHED_DRAIN_TIMEOUT_EN.
module pe_cluster_sched
  import pe_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pe_cluster_sched_if.slave bus
);

  state_t                 r_state, w_state_nxt;
  logic [T_W-1:0]         r_t, w_t_nxt;
  logic [IDX_W-1:0]       r_k, w_k_nxt;
  logic                   r_owner, w_owner_nxt;
  logic [1:0]             r_grant, w_grant_nxt;
  logic [LANES-1:0]       r_lane_valid, w_lane_valid_nxt;
  logic [LANES-1:0]       r_lane_done, w_lane_done_nxt;
  logic [LANES*IDX_W-1:0] r_lane_idx, w_lane_idx_nxt;
  logic                   r_clr, r_cap;
  logic                   w_arb_win, w_arb_any, w_arb_upd, w_all_done;
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
  logic                   r_err, w_err_nxt;
  logic [TMO_W-1:0]       r_tmo, w_tmo_nxt;
`endif

  assign w_all_done = &bus.pe_done;
  assign w_arb_upd  = bus.en && (r_state == CAPTURE);

  pe_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req),
    .i_upd     (w_arb_upd),
    .i_upd_win (r_owner),
    .o_win_c   (w_arb_win),
    .o_any_c   (w_arb_any)
  );

  // Next-state and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_k_nxt     = r_k;
    w_owner_nxt = r_owner;
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
    w_err_nxt   = r_err;
    w_tmo_nxt   = r_tmo;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_owner_nxt = w_arb_win;
          w_k_nxt     = clamp_k(w_arb_win ? bus.k_len1 : bus.k_len0);
          w_state_nxt = CLEAR;
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      CLEAR: begin
        w_state_nxt = FEED;
        w_t_nxt     = '0;
      end
      FEED: begin
        if (r_t == T_W'(r_k) + T_W'(LANES - 2)) begin
          w_state_nxt = DRAIN;
          w_t_nxt     = '0;
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
          w_tmo_nxt   = '0;
`endif
        end else begin
          w_t_nxt = r_t + T_W'(1);
        end
      end
      DRAIN: begin
        if (w_all_done) begin
          w_state_nxt = CAPTURE;
        end
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
        else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_state_nxt = CAPTURE;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
`endif
      end
      CAPTURE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output values for the state being entered, so every output comes straight from a flop.
  always_comb begin
    w_grant_nxt      = (w_state_nxt == IDLE) ? 2'b00 : (w_owner_nxt ? 2'b10 : 2'b01);
    w_lane_valid_nxt = '0;
    w_lane_done_nxt  = '0;
    w_lane_idx_nxt   = '0;
    for (int r = 0; r < int'(LANES); r++) begin
      if (w_state_nxt == FEED) begin
        if (int'(w_t_nxt) >= r && int'(w_t_nxt) < r + int'(w_k_nxt)) begin
          w_lane_valid_nxt[r]            = 1'b1;
          w_lane_idx_nxt[r*IDX_W +: IDX_W] = IDX_W'(int'(w_t_nxt) - r);
        end
        w_lane_done_nxt[r] = int'(w_t_nxt) >= r + int'(w_k_nxt);
      end else if (w_state_nxt == DRAIN || w_state_nxt == CAPTURE) begin
        w_lane_done_nxt[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_t          <= '0;
      r_k          <= '0;
      r_owner      <= 1'b0;
      r_grant      <= '0;
      r_lane_valid <= '0;
      r_lane_done  <= '0;
      r_lane_idx   <= '0;
      r_clr        <= 1'b0;
      r_cap        <= 1'b0;
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
      r_err        <= 1'b0;
      r_tmo        <= '0;
`endif
    end else if (bus.en) begin
      r_state      <= w_state_nxt;
      r_t          <= w_t_nxt;
      r_k          <= w_k_nxt;
      r_owner      <= w_owner_nxt;
      r_grant      <= w_grant_nxt;
      r_lane_valid <= w_lane_valid_nxt;
      r_lane_done  <= w_lane_done_nxt;
      r_lane_idx   <= w_lane_idx_nxt;
      r_clr        <= (w_state_nxt == CLEAR);
      r_cap        <= (w_state_nxt == CAPTURE);
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
      r_err        <= w_err_nxt;
      r_tmo        <= w_tmo_nxt;
`endif
    end
  end

  // Strobes are masked while frozen; the held state re-emits them once en returns.
  assign bus.cluster_clr = r_clr & bus.en;
  assign bus.capture     = r_cap & bus.en;
  assign bus.pass_done   = r_cap & bus.en;
  assign bus.grant       = r_grant;
  assign bus.lane_valid  = r_lane_valid;
  assign bus.lane_idx    = r_lane_idx;
  assign bus.lane_done   = r_lane_done;
`ifdef PE_SCHED_DRAIN_TIMEOUT_EN
  assign bus.err         = r_err;
`else
  assign bus.err         = 1'b0;
`endif

endmodule
